// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: several producers share one FIFO write port.
// Grants are registered one-cycle pulses issued together with the winning
// producer's data. The block also counts acknowledged writes and flags
// failed ones.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic                          err,
  output logic [15:0]                   wr_count
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [LG_W-1:0]         last_grant, last_grant_next;
  logic [LG_W-1:0]         win_idx;
  logic [NUM_REQ-1:0]      eligible, upper_mask, pick, win_oh, gnt_next;
  logic [FIFO_WIDTH-1:0]   win_data, data_next;
  logic                    issue, wr_en_next;

  // A port that was just granted sits out one cycle; a write is held off
  // when the FIFO is full, or almost full with a write already in flight.
  always_comb begin
    eligible = req & ~gnt;
    issue    = en && !fifo_full && !(fifo_almostfull && fifo_wr_en) && (|eligible);
  end

  // Round-robin pick: lowest eligible port above last_grant, else lowest
  // eligible port overall (the wrap-around).
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves a variable unassigned and no latch is inferred.
    upper_mask = '0;
    win_idx    = '0;
    win_oh     = '0;
    win_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_mask[i] = (LG_W'(i) > last_grant);
    end
    pick = ((eligible & upper_mask) != '0) ? (eligible & upper_mask) : eligible;
    // Descending scan so the lowest set bit of pick is the one left standing.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        win_idx    = LG_W'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
        win_data   = data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_next      = IDLE;
    gnt_next        = '0;
    wr_en_next      = 1'b0;
    data_next       = fifo_data_in;
    last_grant_next = last_grant;
    if (issue) begin
      state_next      = ISSUE;
      gnt_next        = win_oh;
      wr_en_next      = 1'b1;
      data_next       = win_data;
      last_grant_next = win_idx;
    end else if (|req) begin
      state_next = STALL;
    end
  end

  // State register plus the registered grant/write outputs. last_grant
  // resets to the top port so the first grant starts the search at port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt          <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      last_grant   <= LG_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state        <= state_next;
      gnt          <= gnt_next;
      fifo_wr_en   <= wr_en_next;
      fifo_data_in <= data_next;
      last_grant   <= last_grant_next;
    end
  end

  // FIFO response to last cycle's write: count acks, latch any failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      wr_count <= '0;
    end else if (fifo_wr_en) begin
      if (fifo_wr_ack) begin
        wr_count <= wr_count + 16'd1;
      end
      if (!fifo_wr_ack || fifo_overflow) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          busy;
  logic                          err;
  logic [15:0]                   wr_count;

  int errors = 0;
  int checks = 0;

  // Reference model state: expected outputs after the most recent edge.
  logic [NUM_REQ-1:0]    m_gnt;
  logic                  m_wr_en;
  logic [FIFO_WIDTH-1:0] m_data;
  int                    m_lg;
  logic                  m_busy;
  logic                  m_err;
  logic [15:0]           m_count;
  bit                    auto_ack;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .FIFO_WIDTH (FIFO_WIDTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .req             (req),
    .data            (data),
    .gnt             (gnt),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .busy            (busy),
    .err             (err),
    .wr_count        (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt   = '0;
    m_wr_en = 1'b0;
    m_data  = '0;
    m_lg    = NUM_REQ - 1;
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_count = '0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt"},      32'(gnt),          32'(m_gnt));
    check({tag, ".wr_en"},    32'(fifo_wr_en),   32'(m_wr_en));
    check({tag, ".data"},     32'(fifo_data_in), 32'(m_data));
    check({tag, ".busy"},     32'(busy),         32'(m_busy));
    check({tag, ".err"},      32'(err),          32'(m_err));
    check({tag, ".wr_count"}, 32'(wr_count),     32'(m_count));
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic step(input string tag);
    logic [NUM_REQ-1:0] elig;
    logic               iss;
    int                 w;
    int                 idx;
    if (auto_ack) fifo_wr_ack = m_wr_en;
    elig = req & ~m_gnt;
    iss  = en && !fifo_full && !(fifo_almostfull && m_wr_en) && (elig != '0);
    if (m_wr_en && fifo_wr_ack) m_count = m_count + 16'd1;
    if (m_wr_en && (!fifo_wr_ack || fifo_overflow)) m_err = 1'b1;
    m_busy = iss || (req != '0);
    if (iss) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (m_lg + k) % NUM_REQ;
        if (w < 0 && elig[idx]) w = idx;
      end
      m_gnt   = NUM_REQ'(1 << w);
      m_wr_en = 1'b1;
      m_data  = data[w*FIFO_WIDTH +: FIFO_WIDTH];
      m_lg    = w;
    end else begin
      m_gnt   = '0;
      m_wr_en = 1'b0;
    end
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    en              = 1'b1;
    req             = '0;
    fifo_full       = 1'b0;
    fifo_almostfull = 1'b0;
    fifo_wr_ack     = 1'b0;
    fifo_overflow   = 1'b0;
    auto_ack        = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
  endtask

  logic [NUM_REQ-1:0] rr_exp [5];

  initial begin
    data = '0;

    // Single port request with an empty FIFO.
    apply_reset();
    data = {16'hD00D, 16'hC0DE, 16'hB0B0, 16'hA0A0};
    req  = 4'b0100;
    step("s1_issue");
    check("s1_gnt",   32'(gnt),          32'h4);
    check("s1_wr_en", 32'(fifo_wr_en),   32'h1);
    check("s1_data",  32'(fifo_data_in), 32'hC0DE);
    req = '0;
    step("s1_ack");
    check("s1_count", 32'(wr_count),     32'h1);
    check("s1_idle",  32'(busy),         32'h0);
    check("s1_hold",  32'(fifo_data_in), 32'hC0DE);

    // All ports requesting continuously: strict rotation 0,1,2,3,0.
    apply_reset();
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step("rr");
      check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
    end
    req = '0;
    step("rr_end");
    check("rr_count", 32'(wr_count), 32'd5);

    // Almost full while a write is in flight blocks exactly that cycle.
    apply_reset();
    req = 4'b0001;
    step("nf_w");
    check("nf_first", 32'(gnt), 32'h1);
    req             = 4'b0010;
    fifo_almostfull = 1'b1;
    step("nf_block");
    check("nf_wr_en", 32'(fifo_wr_en), 32'h0);
    check("nf_stall", 32'(busy),       32'h1);
    check("nf_err",   32'(err),        32'h0);
    step("nf_resume");
    check("nf_gnt",   32'(gnt),        32'h2);
    fifo_almostfull = 1'b0;
    req             = '0;
    step("nf_end");

    // Full FIFO holds everything off; rotation resumes when it drains.
    apply_reset();
    req       = 4'b0011;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("full_hold");
      check("full_gnt",   32'(gnt),        32'h0);
      check("full_wr_en", 32'(fifo_wr_en), 32'h0);
    end
    fifo_full = 1'b0;
    step("full_rel");
    check("full_first", 32'(gnt), 32'h1);
    req = 4'b0010;
    step("full_next");
    check("full_second", 32'(gnt), 32'h2);
    req = '0;
    step("full_end");

    // Missing ack after a write sets the sticky error, count unchanged.
    apply_reset();
    req = 4'b1000;
    step("err_w");
    check("err_wr_en", 32'(fifo_wr_en), 32'h1);
    req         = '0;
    auto_ack    = 1'b0;
    fifo_wr_ack = 1'b0;
    step("err_set");
    check("err_flag",  32'(err),      32'h1);
    check("err_count", 32'(wr_count), 32'h0);
    step("err_hold1");
    step("err_hold2");
    check("err_sticky", 32'(err), 32'h1);
    auto_ack = 1'b1;

    // Reset asserted while a write is on the bus clears everything at once.
    req = 4'b0010;
    step("rst_w");
    check("rst_w_en", 32'(fifo_wr_en), 32'h1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    check_model("rst_async");
    check("rst_count", 32'(wr_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_after");
    check("rst_no_gnt", 32'(gnt), 32'h0);

    // Randomized traffic against the model.
    apply_reset();
    auto_ack = 1'b0;
    for (int c = 0; c < 400; c++) begin
      en              = ($urandom_range(0, 9) != 0);
      fifo_full       = ($urandom_range(0, 7) == 0);
      fifo_almostfull = ($urandom_range(0, 3) == 0);
      fifo_overflow   = ($urandom_range(0, 99) == 0);
      fifo_wr_ack     = m_wr_en ? ($urandom_range(0, 49) != 0) : 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_gnt[i]) begin
          req[i] = 1'b0;
        end else if (req[i] && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          data[i*FIFO_WIDTH +: FIFO_WIDTH] = FIFO_WIDTH'($urandom);
        end
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of producer ports (2..8).
REQ-002 The module SHALL have parameter FIFO_WIDTH, default 16, giving the data width and matching the shared FIFO.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  when low, no new grants are issued.
REQ-006 req  input  NUM_REQ  per-producer write request, held high with data stable until granted.
REQ-007 data  input  NUM_REQ*FIFO_WIDTH  producer data; slice i is [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 gnt  output  NUM_REQ  one-hot, one-cycle pulse meaning "your data was issued to the FIFO".
REQ-009 fifo_wr_en  output  1  write enable to the FIFO.
REQ-010 fifo_data_in  output  FIFO_WIDTH  write data to the FIFO.
REQ-011 fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow  input  1 each  FIFO status flags.
REQ-012 busy  output  1  high when the state is not IDLE.
REQ-013 err  output  1  sticky write-error flag.
REQ-014 wr_count  output  16  count of acknowledged writes.

Function
REQ-015 gnt, fifo_wr_en and fifo_data_in SHALL be registered; a requester sampled at edge N sees gnt and fifo_wr_en high in the cycle after edge N.
REQ-016 The issue condition SHALL be: en && !fifo_full && !(fifo_almostfull && fifo_wr_en) && at least one eligible request.
REQ-017 Requester i SHALL be ineligible in any cycle where gnt[i]=1, so each producer is issued at most once every two cycles.
REQ-018 The winner SHALL be the first eligible requester found searching round-robin from last_grant+1 upward, wrapping at NUM_REQ-1 to 0.
REQ-019 On issue, fifo_wr_en SHALL be 1, fifo_data_in SHALL be the winner's data slice, gnt SHALL be the winner's one-hot bit, and last_grant SHALL become the winner.
REQ-020 When the issue condition is false, fifo_wr_en and gnt SHALL be 0 for the next cycle, and fifo_data_in SHALL hold its value.
REQ-021 The FSM SHALL have states IDLE, ISSUE and STALL, with these transitions at each edge:
- to ISSUE if the issue condition holds;
- otherwise to STALL if any req is high;
- otherwise to IDLE.
REQ-022 In the cycle after fifo_wr_en=1, fifo_wr_ack=1 SHALL increment wr_count by 1, wrapping from 16'hFFFF to 0.
REQ-023 err SHALL set, and remain set until reset, when either occurs in the cycle after fifo_wr_en=1:
- fifo_wr_ack=0;
- fifo_overflow=1.
REQ-024 Requests dropped before grant SHALL be discarded without error.

Reset
REQ-025 When rst_n is low, the following SHALL take effect immediately:
- state = IDLE;
- gnt = 0, fifo_wr_en = 0, fifo_data_in = 0;
- busy = 0, err = 0, wr_count = 0;
- last_grant = NUM_REQ-1.
REQ-026 Reset asserted while fifo_wr_en=1 SHALL abort the write; no gnt pulse SHALL follow after release.
REQ-027 The first grant after reset SHALL go to the lowest-numbered requesting port.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Single port: req=4'b0100, FIFO empty -> next cycle gnt=4'b0100, fifo_wr_en=1, fifo_data_in=data[2]; wr_count=1 two cycles after the request.
- Round-robin: req=4'b1111 held after reset -> grant order 0,1,2,3,0; no port granted in consecutive cycles.
- Near full: fifo_almostfull=1 while fifo_wr_en=1 -> no issue that cycle; state=STALL; err stays 0.
- Full: fifo_full=1 with req=4'b0011 -> gnt=0 and fifo_wr_en=0 while full; the first grant goes to the round-robin winner after full drops.
- Error: forcing fifo_wr_ack=0 after a write -> err=1 next edge and held; wr_count unchanged.
- Reset mid-write: rst_n low while fifo_wr_en=1 -> all outputs 0 immediately; wr_count=0.
